// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared constants, line/entry types and line rotation helper for the DRAM read-return path
package dram_pkg;

  localparam int WORD_W    = 32;
  localparam int BURST_LEN = 8;
  localparam int OFF_W     = $clog2(BURST_LEN);
  localparam int TAG_W     = 4;

  typedef logic [BURST_LEN-1:0][WORD_W-1:0] rd_line_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [OFF_W-1:0] offset;
    rd_line_t         line;
    logic             full;
  } rd_entry_t;

  // Word (offset+k) mod BURST_LEN lands in slot k; BURST_LEN is a power of 2 so the index wraps for free.
  function automatic rd_line_t rotate_line(rd_line_t line, logic [OFF_W-1:0] offset);
    rd_line_t         res;
    logic [OFF_W-1:0] idx;
    for (int k = 0; k < BURST_LEN; k++) begin
      idx    = offset + OFF_W'(k);
      res[k] = line[idx];
    end
    return res;
  endfunction

endpackage

// File: rtl/dram_rd_line_buf.sv
// rtl/dram_rd_line_buf.sv - DEPTH-entry read-return storage with meta, word-write and async head read ports
module dram_rd_line_buf
  import dram_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             meta_we,
  input  logic [IDX_W-1:0] meta_idx,
  input  logic [TAG_W-1:0] meta_tag,
  input  logic [OFF_W-1:0] meta_offset,
  input  logic             word_we,
  input  logic [IDX_W-1:0] word_idx,
  input  logic [OFF_W-1:0] word_sel,
  input  logic [WORD_W-1:0] word_data,
  input  logic             set_full,
  input  logic             pop,
  input  logic [IDX_W-1:0] head_idx,
  output rd_entry_t        head
);

  rd_entry_t mem [DEPTH];

  assign head = mem[head_idx];

  // Only the full bits need reset; tag/offset/line are always rewritten before they are observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].full <= 1'b0;
      end
    end else begin
      if (meta_we) begin
        mem[meta_idx].tag    <= meta_tag;
        mem[meta_idx].offset <= meta_offset;
        mem[meta_idx].full   <= 1'b0;
      end
      if (word_we) begin
        mem[word_idx].line[word_sel] <= word_data;
        if (set_full) begin
          mem[word_idx].full <= 1'b1;
        end
      end
      if (pop) begin
        mem[head_idx].full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dram_rd_return.sv
// rtl/dram_rd_return.sv - collects BL8 read beats into lines, returns them in issue order; DRAM_RD_CRITICAL_FIRST_EN rotates resp_data
module dram_rd_return #(
  parameter int WORD_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int DEPTH     = 4,
  parameter int TAG_W     = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        rd_issue,
  input  logic [TAG_W-1:0]            rd_tag,
  input  logic [2:0]                  rd_offset,
  output logic                        rd_ready,
  input  logic                        beat_valid,
  input  logic [WORD_W-1:0]           beat_data,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [BURST_LEN*WORD_W-1:0] resp_data,
  output logic [WORD_W-1:0]           resp_word,
  output logic [TAG_W-1:0]            resp_tag,
  output logic                        err_ovf,
  output logic                        err_orphan
);
  import dram_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] alloc_ptr, fill_ptr, pop_ptr, count;
  logic [OFF_W-1:0] beat_cnt;
  logic             do_alloc, do_fill, do_pop, last_beat;
  rd_entry_t        head;
  rd_line_t         line_out;

  assign count     = alloc_ptr - pop_ptr;
  assign rd_ready  = (count != PTR_W'(DEPTH));
  assign do_alloc  = rd_issue && rd_ready;
  // An unfilled entry exists only when fill lags alloc; a beat in the same cycle as its READ is orphaned.
  assign do_fill   = beat_valid && (fill_ptr != alloc_ptr);
  assign last_beat = (beat_cnt == OFF_W'(BURST_LEN - 1));
  assign resp_valid = head.full && (count != '0);
  assign do_pop    = resp_valid && resp_ready;

`ifdef DRAM_RD_CRITICAL_FIRST_EN
  assign line_out = rotate_line(head.line, head.offset);
`else
  assign line_out = head.line;
`endif

  // Outputs read as zero while nothing is presented so reset leaves them cleared.
  assign resp_data = resp_valid ? line_out : '0;
  assign resp_word = resp_valid ? head.line[head.offset] : '0;
  assign resp_tag  = resp_valid ? head.tag : '0;

  dram_rd_line_buf #(.DEPTH(DEPTH)) u_line_buf (
    .clk         (CLK),
    .rst         (RST),
    .meta_we     (do_alloc),
    .meta_idx    (alloc_ptr[IDX_W-1:0]),
    .meta_tag    (rd_tag),
    .meta_offset (rd_offset),
    .word_we     (do_fill),
    .word_idx    (fill_ptr[IDX_W-1:0]),
    .word_sel    (beat_cnt),
    .word_data   (beat_data),
    .set_full    (last_beat),
    .pop         (do_pop),
    .head_idx    (pop_ptr[IDX_W-1:0]),
    .head        (head)
  );

  // Pointers, beat counter and sticky error flags; each pointer advances independently.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alloc_ptr  <= '0;
      fill_ptr   <= '0;
      pop_ptr    <= '0;
      beat_cnt   <= '0;
      err_ovf    <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      if (do_alloc) begin
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (rd_issue && !rd_ready) begin
        err_ovf <= 1'b1;
      end
      if (do_fill) begin
        if (last_beat) begin
          beat_cnt <= '0;
          fill_ptr <= fill_ptr + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (beat_valid && !do_fill) begin
        err_orphan <= 1'b1;
      end
      if (do_pop) begin
        pop_ptr <= pop_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dram_rd_return.sv
// tb/tb_dram_rd_return.sv - scoreboard bench for dram_rd_return (honours DRAM_RD_CRITICAL_FIRST_EN)
`timescale 1ns/1ps
module tb_dram_rd_return;

  localparam int WORD_W    = 32;
  localparam int BURST_LEN = 8;
  localparam int DEPTH     = 4;
  localparam int TAG_W     = 4;
  localparam int LINE_W    = BURST_LEN * WORD_W;

  logic              clk = 1'b0;
  logic              rst, rd_issue, rd_ready, beat_valid, resp_valid, resp_ready;
  logic [TAG_W-1:0]  rd_tag, resp_tag;
  logic [2:0]        rd_offset;
  logic [WORD_W-1:0] beat_data, resp_word;
  logic [LINE_W-1:0] resp_data;
  logic              err_ovf, err_orphan;

  always #5 clk = ~clk;

  dram_rd_return #(.WORD_W(WORD_W), .BURST_LEN(BURST_LEN), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .CLK(clk), .RST(rst),
    .rd_issue(rd_issue), .rd_tag(rd_tag), .rd_offset(rd_offset), .rd_ready(rd_ready),
    .beat_valid(beat_valid), .beat_data(beat_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_word(resp_word), .resp_tag(resp_tag),
    .err_ovf(err_ovf), .err_orphan(err_orphan)
  );

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-1:0] word;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got tag %0h, required no response", resp_tag);
      end else begin
        mon_e = sb.pop_front();
        check("resp_tag", resp_tag, mon_e.tag);
        check("resp_word", resp_word, mon_e.word);
        check("resp_data", resp_data, mon_e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [TAG_W-1:0] t, input logic [2:0] o);
    rd_issue = 1'b1; rd_tag = t; rd_offset = o;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic beat(input logic [WORD_W-1:0] d);
    beat_valid = 1'b1; beat_data = d;
    tick();
    beat_valid = 1'b0;
  endtask

  // Beats of a burst follow base + step*i; n beats are sent back to back.
  task automatic burst(input logic [WORD_W-1:0] base, input logic [WORD_W-1:0] step, input int n);
    for (int i = 0; i < n; i++) beat(base + step * WORD_W'(i));
  endtask

  task automatic push_exp(input logic [TAG_W-1:0] t, input logic [2:0] o,
                          input logic [WORD_W-1:0] base, input logic [WORD_W-1:0] step);
    exp_t e;
    e.tag  = t;
    e.word = base + step * WORD_W'(o);
    for (int k = 0; k < BURST_LEN; k++) begin
`ifdef DRAM_RD_CRITICAL_FIRST_EN
      e.data[k*WORD_W +: WORD_W] = base + step * WORD_W'((int'(o) + k) % BURST_LEN);
`else
      e.data[k*WORD_W +: WORD_W] = base + step * WORD_W'(k);
`endif
    end
    sb.push_back(e);
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while (sb.size() != 0 && c < budget) begin
      tick();
      c++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d responses outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_rd_ready"}, rd_ready, 1'b1);
    check({pfx, "_resp_valid"}, resp_valid, 1'b0);
    check({pfx, "_resp_data"}, resp_data, '0);
    check({pfx, "_resp_word"}, resp_word, '0);
    check({pfx, "_resp_tag"}, resp_tag, '0);
    check({pfx, "_err_ovf"}, err_ovf, 1'b0);
    check({pfx, "_err_orphan"}, err_orphan, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rd_issue = 1'b0; rd_tag = '0; rd_offset = '0;
    beat_valid = 1'b0; beat_data = '0; resp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset_state("reset");

    // 1: single read, tag 3 offset 2
    issue(4'd3, 3'd2);
    tick();
    burst(32'h11111111, 32'h11111111, 7);
    check("t1_valid_before_last", resp_valid, 1'b0);
    beat(32'h88888888);
    check("t1_valid_after_last", resp_valid, 1'b1);
    check("t1_tag", resp_tag, 4'd3);
    check("t1_word", resp_word, 32'h33333333);
`ifdef DRAM_RD_CRITICAL_FIRST_EN
    check("t1_word0", resp_data[31:0], 32'h33333333);
`else
    check("t1_word0", resp_data[31:0], 32'h11111111);
`endif
    push_exp(4'd3, 3'd2, 32'h11111111, 32'h11111111);
    resp_ready = 1'b1;
    drain("t1_drain", 20);
    resp_ready = 1'b0;

    // 2: fill to full, overflow, pop one
    issue(4'd8, 3'd5);
    issue(4'd9, 3'd0);
    issue(4'd10, 3'd1);
    check("t2_ready_3", rd_ready, 1'b1);
    issue(4'd11, 3'd2);
    check("t2_ready_full", rd_ready, 1'b0);
    check("t2_ovf_before", err_ovf, 1'b0);
    issue(4'd12, 3'd3);
    check("t2_ovf_after", err_ovf, 1'b1);
    burst(32'hA0000000, 32'h1, 8);
    check("t2_valid", resp_valid, 1'b1);
    tick();
    check("t2_hold_tag", resp_tag, 4'd8);
    check("t2_hold_word", resp_word, 32'hA0000005);
    check("t2_ready_still_full", rd_ready, 1'b0);
    push_exp(4'd8, 3'd5, 32'hA0000000, 32'h1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t2_ready_after_pop", rd_ready, 1'b1);
    push_exp(4'd9, 3'd0, 32'hB0000000, 32'h10);
    burst(32'hB0000000, 32'h10, 8);
    resp_ready = 1'b1;
    drain("t2_drain", 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t2_ovf_cleared", err_ovf, 1'b0);

    // 3: back-to-back bursts, resp_ready held high
    resp_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      issue(TAG_W'(t), 3'(t));
      push_exp(TAG_W'(t), 3'(t), 32'h0C000000 + 32'(t) * 32'h00100000, 32'h00010001);
    end
    check("t3_ready_full", rd_ready, 1'b0);
    for (int t = 0; t < 4; t++) begin
      burst(32'h0C000000 + 32'(t) * 32'h00100000, 32'h00010001, 8);
    end
    drain("t3_drain", 20);

    // 4: orphan beat with nothing allocated
    beat(32'hDEADBEEF);
    check("t4_orphan", err_orphan, 1'b1);
    check("t4_no_valid", resp_valid, 1'b0);
    check("t4_ready", rd_ready, 1'b1);
    issue(4'd1, 3'd4);
    push_exp(4'd1, 3'd4, 32'h44440000, 32'h3);
    burst(32'h44440000, 32'h3, 8);
    drain("t4_drain", 20);

    // 5: issue, last beat and pop in one cycle
    resp_ready = 1'b0;
    issue(4'd5, 3'd0);
    issue(4'd6, 3'd1);
    push_exp(4'd5, 3'd0, 32'h50000000, 32'h10);
    burst(32'h50000000, 32'h10, 8);
    push_exp(4'd6, 3'd1, 32'h60000000, 32'h100);
    burst(32'h60000000, 32'h100, 7);
    rd_issue = 1'b1; rd_tag = 4'd7; rd_offset = 3'd6;
    beat_valid = 1'b1; beat_data = 32'h60000700;
    resp_ready = 1'b1;
    tick();
    rd_issue = 1'b0; beat_valid = 1'b0; resp_ready = 1'b0;
    check("t5_ready", rd_ready, 1'b1);
    check("t5_head_valid", resp_valid, 1'b1);
    check("t5_head_tag", resp_tag, 4'd6);
    issue(4'd9, 3'd2);
    check("t5_ready_count3", rd_ready, 1'b1);
    issue(4'd10, 3'd3);
    check("t5_ready_count4", rd_ready, 1'b0);
    push_exp(4'd7, 3'd6, 32'h70000000, 32'h7);
    burst(32'h70000000, 32'h7, 8);
    push_exp(4'd9, 3'd2, 32'h90000000, 32'h9);
    burst(32'h90000000, 32'h9, 8);
    push_exp(4'd10, 3'd3, 32'hA5000000, 32'h1000);
    burst(32'hA5000000, 32'h1000, 8);
    resp_ready = 1'b1;
    drain("t5_drain", 20);

    // 6: reset mid-burst
    issue(4'd4, 3'd1);
    burst(32'hE0000000, 32'h1, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("t6");
    burst(32'hE0000005, 32'h1, 3);
    check("t6_orphan", err_orphan, 1'b1);
    check("t6_no_valid", resp_valid, 1'b0);
    issue(4'd2, 3'd7);
    push_exp(4'd2, 3'd7, 32'h22220000, 32'h11);
    burst(32'h22220000, 32'h11, 8);
    drain("t6_drain", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_rd_return.md
# dram_rd_return

Read-return collector sitting directly downstream of `data_transfer` in the DRAM path. It captures the 32-bit beats that `data_transfer` deserializes from the four x8 DDR4 devices, packs each BL8 burst into a 256-bit line, and pairs that line with the tag and column offset recorded when the control unit issued the READ. It returns completed lines in issue order over a valid/ready handshake and back-pressures READ issue when its line buffer is full.

## Interface
- `WORD_W`, 32, beat width (4 devices × 8 DQ)
- `BURST_LEN`, 8, beats per burst (BL8)
- `DEPTH`, 4, outstanding-read entries; power of 2, ≥2
- `TAG_W`, 4, requester tag width
- `CLK` in 1: the only clock.
- `RST` in 1: reset, synchronous, active-high.
- `rd_issue` in 1: control unit issued a READ this cycle.
- `rd_tag` in TAG_W: tag for the issued READ.
- `rd_offset` in 3: requested word index within the burst (`COL_choice`).
- `rd_ready` out 1: an entry is free; the control unit must not assert `rd_issue` while this is low.
- `beat_valid` in 1: a deserialized beat is present on `beat_data`.
- `beat_data` in WORD_W: beat payload, delivered in burst order.
- `resp_valid` out 1: head entry complete.
- `resp_ready` in 1: consumer accepts the head entry.
- `resp_data` out BURST_LEN*WORD_W: full line; word i sits at bits [i*WORD_W +: WORD_W].
- `resp_word` out WORD_W: the word selected by the stored offset.
- `resp_tag` out TAG_W: stored tag.
- `err_ovf` out 1: sticky; `rd_issue` arrived while `rd_ready` was 0.
- `err_orphan` out 1: sticky; a beat arrived with no allocated, unfilled entry.

## Operation
- The circular buffer holds DEPTH entries of {tag, offset, line, full}. It uses three pointers of log2(DEPTH)+1 bits each: `alloc_ptr`, `fill_ptr`, `pop_ptr`. Pointers wrap naturally; the extra MSB distinguishes full from empty.
- `count = alloc_ptr - pop_ptr`. `rd_ready = (count != DEPTH)` and is computed from registered state only. A pop in the same cycle does not bypass this check.
- Allocate: when `rd_issue && rd_ready`, write the tag and offset at `alloc_ptr`, clear `full`, and increment `alloc_ptr`. When `rd_issue && !rd_ready`, drop the request and set `err_ovf`.
- Fill: a beat is accepted when `beat_valid` is high and `fill_ptr != alloc_ptr`.
  - The beat is written to word `beat_cnt` of the entry at `fill_ptr`, and `beat_cnt` increments.
  - On beat BURST_LEN-1, set `full`, increment `fill_ptr`, and reset `beat_cnt` to 0.
  - If `beat_valid` is high with `fill_ptr == alloc_ptr`, drop the beat and set `err_orphan`.
- Allocate and first beat in the same cycle: the beat is orphaned. Data cannot precede its READ by less than CL, so this case never occurs legally.
- Pop: `resp_valid = full[pop_ptr] && (count != 0)`. On `resp_valid && resp_ready`, clear `full` and increment `pop_ptr`.
- Allocate, fill and pop may all occur in the same cycle. Each pointer updates independently.
- `resp_word = line[offset]` of the head entry.
- Error flags clear only on `RST`.

## Timing
- Reset values:
  - `rd_ready`=1
  - `resp_valid`=0
  - `resp_data`=0
  - `resp_word`=0
  - `resp_tag`=0
  - `err_ovf`=0
  - `err_orphan`=0
  - all pointers and `beat_cnt` = 0; `full` bits cleared
- Latency: if the last beat is accepted at edge N, `resp_valid` is high after edge N (visible in cycle N+1). If the entry is already at the head, there are no further bubbles.
- Outputs hold stable while `resp_valid && !resp_ready`.
- Back-to-back bursts are supported: the beat after beat 7 targets the next entry with no gap.
- `RST` mid-burst discards partial lines and pending tags. Any beats still in flight afterwards set `err_orphan`.
- Throughput: one response per cycle when `resp_ready` stays high.

## Configuration
- `DRAM_RD_CRITICAL_FIRST_EN`
  - Defined: `resp_data` is rotated so the requested word (`offset`) appears at word 0 and word (offset+k) mod 8 appears at word k.
  - Undefined: natural burst order.
- `resp_word` is identical in both builds.

## Structure
- `dram_pkg` holds:
  - `WORD_W` and `BURST_LEN` constants
  - `rd_line_t` (BURST_LEN×WORD_W packed array)
  - `rd_entry_t` struct {tag, offset, line, full}
- One sub-module, `dram_rd_line_buf`, implements the DEPTH-entry storage array: write-word port for fill, write-meta port for allocate, and an async read of the head entry. The top level owns the pointers, `beat_cnt`, and the error flags.

## Test plan
1. Single read: issue tag 3, offset 2, then beats 0x11111111..0x88888888.
   - Expect `resp_valid` the cycle after the 8th beat.
   - Expect `resp_tag`=3 and `resp_word`=0x33333333.
   - Expect `resp_data` word0=0x11111111 (macro off) or 0x33333333 (macro on).
2. Fill to full: issue 4 reads with `resp_ready`=0.
   - Expect `rd_ready`=0 after the 4th.
   - A 5th issue sets `err_ovf` and is dropped.
   - Pop one: `rd_ready`=1 the next cycle.
3. Back-to-back: 4 issues (tags 0–3), then 32 contiguous beats, with `resp_ready`=1.
   - Expect 4 responses in tag order 0,1,2,3, each line correct.
4. Orphan beat: `beat_valid` with nothing allocated.
   - Expect `err_orphan`=1, no `resp_valid`, and pointers unchanged.
5. Simultaneous events: in one cycle, issue tag 7, write the last beat of the head entry, and pop the previous head.
   - Expect `count` unchanged and the tag-7 entry filled next.
6. Reset mid-burst: 5 beats in, assert `RST`.
   - Expect all outputs at their reset values.
   - The remaining 3 beats set `err_orphan`.
   - A new read then completes correctly.
